// File: rtl/uart_cmd_parser.sv
// Assembles 4-byte command frames (header, addr, data, addr^data) from a UART
// byte stream into register-write strobes, flagging bad checksums and stalls.
module uart_cmd_parser #(
  parameter logic [7:0] HEADER  = 8'h55,
  parameter int         TIMEOUT = 1_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Done,
  output logic       Wr_En,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Frame_Err,
  output logic [1:0] Err_Code,
  output logic       Busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       data_reg, data_next;
  logic             wr_en_reg, wr_en_next;
  logic [7:0]       wr_addr_reg, wr_addr_next;
  logic [7:0]       wr_data_reg, wr_data_next;
  logic             frame_err_reg, frame_err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic             busy_reg;
  logic             timeout;

  // The stall fires when the count is about to reach TIMEOUT-1; a byte
  // arriving in that same cycle takes priority and restarts the count.
  assign cnt_inc = cnt_reg + CNT_W'(1);
  assign timeout = (state_reg != IDLE) && !Rx_Done && (cnt_inc == CNT_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= 8'h00;
      wr_data_reg   <= 8'h00;
      frame_err_reg <= 1'b0;
      err_code_reg  <= 2'b00;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      frame_err_reg <= frame_err_next;
      err_code_reg  <= err_code_next;
      busy_reg      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_inc;
    addr_next      = addr_reg;
    data_next      = data_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (Rx_Done && (Rx_Data == HEADER)) begin
          state_next = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (Rx_Done) begin
          addr_next  = Rx_Data;
          cnt_next   = '0;
          state_next = GET_DATA;
        end
      end
      GET_DATA: begin
        if (Rx_Done) begin
          data_next  = Rx_Data;
          cnt_next   = '0;
          state_next = GET_CHK;
        end
      end
      GET_CHK: begin
        if (Rx_Done) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (Rx_Data == (addr_reg ^ data_reg)) begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = data_reg;
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = 2'b01;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (timeout) begin
      state_next     = IDLE;
      cnt_next       = '0;
      frame_err_next = 1'b1;
      err_code_next  = 2'b10;
    end
  end

  assign Wr_En     = wr_en_reg;
  assign Wr_Addr   = wr_addr_reg;
  assign Wr_Data   = wr_data_reg;
  assign Frame_Err = frame_err_reg;
  assign Err_Code  = err_code_reg;
  assign Busy      = busy_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized checks of uart_cmd_parser against a frame-level
// model built from byte timestamps and a payload queue.
module tb_uart_cmd_parser;

  localparam int         TO  = 100;
  localparam logic [7:0] HDR = 8'h55;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rx_Done = 1'b0;
  logic       Wr_En;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Frame_Err;
  logic [1:0] Err_Code;
  logic       Busy;

  uart_cmd_parser #(.HEADER(HDR), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Rx_Data(Rx_Data), .Rx_Done(Rx_Done),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Frame_Err(Frame_Err), .Err_Code(Err_Code), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a frame is "open" after a header; payload bytes are
  // queued with the time of the last accepted byte.
  bit         in_frame;
  logic [7:0] fq[$];
  longint     now = 0;
  longint     last_t = 0;
  logic       e_wr, e_err, e_busy;
  logic [1:0] e_code;
  logic [7:0] e_addr, e_data;

  function void model_reset();
    in_frame = 1'b0;
    fq.delete();
    e_wr = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    e_code = 2'b00; e_addr = 8'h00; e_data = 8'h00;
  endfunction

  function void model_cycle(bit v, logic [7:0] b);
    e_wr  = 1'b0;
    e_err = 1'b0;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    if (in_frame && !v && (now - last_t == longint'(TO - 1))) begin
      in_frame = 1'b0;
      e_err    = 1'b1;
      e_code   = 2'b10;
    end else if (v) begin
      if (!in_frame) begin
        if (b == HDR) begin
          in_frame = 1'b1;
          fq.delete();
          last_t = now;
        end
      end else begin
        fq.push_back(b);
        last_t = now;
        if (fq.size() == 3) begin
          in_frame = 1'b0;
          if ((fq[0] ^ fq[1]) == fq[2]) begin
            e_wr = 1'b1; e_addr = fq[0]; e_data = fq[1];
          end else begin
            e_err = 1'b1; e_code = 2'b01;
          end
        end
      end
    end
    e_busy = in_frame;
  endfunction

  task automatic expect_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, now, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [20:0] obs, exp;
    obs = {Wr_En, Frame_Err, Busy, Err_Code, Wr_Addr, Wr_Data};
    exp = {e_wr, e_err, e_busy, e_code, e_addr, e_data};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL cycle t=%0d observed{we,err,busy,code,addr,data}=%h expected=%h",
             now, obs, exp);
    end
  endtask

  task automatic step(bit v, logic [7:0] b);
    Rx_Done = v;
    Rx_Data = v ? b : 8'($urandom);
    model_cycle(v, b);
    @(posedge Clk);
    #1;
    now++;
    check_all();
    if (e_wr)  $display("[TB] t=%0d write addr=%h data=%h", now, e_addr, e_data);
    if (e_err) $display("[TB] t=%0d frame error code=%b", now, e_code);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send4(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    step(1'b1, a); step(1'b1, b); step(1'b1, c); step(1'b1, d);
  endtask

  function automatic int rand_gap();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(TO - 3, TO));
    return int'($urandom_range(0, 2));
  endfunction

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    expect_eq("rst_wr_en", 32'(Wr_En), 32'd0);
    expect_eq("rst_frame_err", 32'(Frame_Err), 32'd0);
    expect_eq("rst_busy", 32'(Busy), 32'd0);
    expect_eq("rst_err_code", 32'(Err_Code), 32'd0);
    expect_eq("rst_wr_addr", 32'(Wr_Addr), 32'd0);
    expect_eq("rst_wr_data", 32'(Wr_Data), 32'd0);
    Reset_n = 1'b1;

    // Valid frame
    step(1'b1, 8'h55);
    expect_eq("hdr_busy", 32'(Busy), 32'd1);
    step(1'b1, 8'h12); step(1'b1, 8'h34); step(1'b1, 8'h26);
    expect_eq("valid_wr_en", 32'(Wr_En), 32'd1);
    expect_eq("valid_addr", 32'(Wr_Addr), 32'h12);
    expect_eq("valid_data", 32'(Wr_Data), 32'h34);
    expect_eq("valid_busy", 32'(Busy), 32'd0);
    idle(1);
    expect_eq("valid_pulse_len", 32'(Wr_En), 32'd0);

    // Bad checksum, then a good frame
    send4(8'h55, 8'h12, 8'h34, 8'h27);
    expect_eq("badchk_err", 32'(Frame_Err), 32'd1);
    expect_eq("badchk_code", 32'(Err_Code), 32'b01);
    expect_eq("badchk_wr_en", 32'(Wr_En), 32'd0);
    expect_eq("badchk_addr_held", 32'(Wr_Addr), 32'h12);
    send4(8'h55, 8'h01, 8'h02, 8'h03);
    expect_eq("after_bad_addr", 32'(Wr_Addr), 32'h01);
    expect_eq("after_bad_data", 32'(Wr_Data), 32'h02);
    expect_eq("code_held", 32'(Err_Code), 32'b01);

    // Garbage then a frame with a header-valued address
    step(1'b1, 8'hAA); step(1'b1, 8'h00);
    expect_eq("garbage_no_err", 32'(Frame_Err), 32'd0);
    step(1'b1, 8'h55); step(1'b1, 8'h55); step(1'b1, 8'hFF); step(1'b1, 8'hAA);
    expect_eq("hdr_as_addr", 32'(Wr_Addr), 32'h55);
    expect_eq("hdr_as_addr_data", 32'(Wr_Data), 32'hFF);
    expect_eq("hdr_as_addr_we", 32'(Wr_En), 32'd1);

    // Timeout: error lands exactly TO cycles after the last byte
    step(1'b1, 8'h55); step(1'b1, 8'h12);
    idle(TO - 2);
    expect_eq("to_not_yet", 32'(Frame_Err), 32'd0);
    idle(1);
    expect_eq("to_err", 32'(Frame_Err), 32'd1);
    expect_eq("to_code", 32'(Err_Code), 32'b10);
    expect_eq("to_busy", 32'(Busy), 32'd0);
    send4(8'h55, 8'h12, 8'h34, 8'h26);
    expect_eq("to_recover", 32'(Wr_En), 32'd1);

    // Boundary: DATA 99 cycles after ADDR is accepted, 100 cycles is late
    step(1'b1, 8'h55); step(1'b1, 8'h12);
    idle(TO - 2);
    step(1'b1, 8'h34);
    expect_eq("bnd_ok_busy", 32'(Busy), 32'd1);
    expect_eq("bnd_ok_err", 32'(Frame_Err), 32'd0);
    step(1'b1, 8'h26);
    expect_eq("bnd_ok_we", 32'(Wr_En), 32'd1);
    step(1'b1, 8'h55); step(1'b1, 8'h12);
    idle(TO - 1);
    expect_eq("bnd_late_err", 32'(Frame_Err), 32'd1);
    step(1'b1, 8'h34);
    expect_eq("bnd_late_discard", 32'(Busy), 32'd0);
    step(1'b1, 8'h26);
    expect_eq("bnd_late_no_we", 32'(Wr_En), 32'd0);

    // Reset mid-frame
    step(1'b1, 8'h55); step(1'b1, 8'h12);
    Reset_n = 1'b0;
    #1;
    model_reset();
    expect_eq("async_rst_busy", 32'(Busy), 32'd0);
    expect_eq("async_rst_addr", 32'(Wr_Addr), 32'd0);
    expect_eq("async_rst_code", 32'(Err_Code), 32'd0);
    idle(3);
    Reset_n = 1'b1;
    step(1'b1, 8'h34); step(1'b1, 8'h26);
    idle(1);
    expect_eq("rst_mid_no_we", 32'(Wr_En), 32'd0);
    expect_eq("rst_mid_no_err", 32'(Frame_Err), 32'd0);
    expect_eq("rst_mid_addr", 32'(Wr_Addr), 32'd0);

    // Randomized frames with occasional stalls near the timeout boundary
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [7:0] a, d, c;
      kind = int'($urandom_range(0, 5));
      a = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
      d = 8'($urandom);
      c = a ^ d;
      if (kind == 1) c = c ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 0) begin
        idle(rand_gap());
        step(1'b1, 8'($urandom));
      end else if (kind == 2) begin
        idle(rand_gap()); step(1'b1, HDR);
        idle(rand_gap()); step(1'b1, a);
        idle(TO + 2);
      end else begin
        idle(rand_gap()); step(1'b1, HDR);
        idle(rand_gap()); step(1'b1, a);
        idle(rand_gap()); step(1'b1, d);
        idle(rand_gap()); step(1'b1, c);
      end
    end
    idle(TO + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Downstream consumer of `uart_byte_rx` in the UART suite. It takes the received byte stream (`Rx_Data`/`Rx_Done`) and assembles fixed 4-byte command frames of the form header, address, data, checksum. Each valid frame produces a single-cycle register-write strobe. Bad checksums and stalled frames are reported on an error pulse with a cause code, and the parser then resynchronises to the next header.

## Interface
- `HEADER`, default 8'h55: frame start byte.
- `TIMEOUT`, default 1_000_000: maximum clock cycles allowed between consecutive bytes of one frame (20 ms at 50 MHz). Legal range is ≥ 2. The counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `Clk`  in  1  system clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Rx_Data`  in  8  received byte; valid in any cycle where `Rx_Done`=1.
- `Rx_Done`  in  1  one-cycle strobe per received byte.
- `Wr_En`  out  1  one-cycle write strobe for a valid frame.
- `Wr_Addr`  out  8  address of the last valid frame; held between writes.
- `Wr_Data`  out  8  data of the last valid frame; held between writes.
- `Frame_Err`  out  1  one-cycle error strobe.
- `Err_Code`  out  2  cause of the last error: 2'b01 checksum, 2'b10 timeout; held until the next error.
- `Busy`  out  1  high while a frame is partially received (state ≠ IDLE).

## Operation
- Frame format: `HEADER`, ADDR, DATA, CHK, where CHK = ADDR ^ DATA.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_CHK. A byte is accepted only in a cycle with `Rx_Done`=1.
- IDLE:
  - byte == `HEADER` → GET_ADDR.
  - any other byte is discarded silently; no error.
- GET_ADDR: latch the byte into the internal addr register → GET_DATA.
- GET_DATA: latch the byte into the internal data register → GET_CHK.
- GET_CHK: compare the byte with addr ^ data, then go to IDLE.
  - Match: load `Wr_Addr`/`Wr_Data` and pulse `Wr_En`.
  - Mismatch: pulse `Frame_Err`, set `Err_Code`=2'b01. `Wr_Addr`/`Wr_Data` are unchanged.
- A `HEADER`-valued byte inside a frame (in any state other than IDLE) is treated as ordinary payload. There is no mid-frame resync.
- Timeout counter:
  - Cleared on every accepted byte and while in IDLE.
  - Otherwise increments by 1 per cycle.
  - When the count reaches `TIMEOUT`-1 with no `Rx_Done` in that cycle: pulse `Frame_Err`, set `Err_Code`=2'b10, go to IDLE. The partial frame is dropped.
- Simultaneous byte and timeout boundary: if `Rx_Done` is high in the cycle the count reaches `TIMEOUT`-1, the byte wins. It is processed normally, the counter clears, and no timeout is flagged.
- `Wr_En` and `Frame_Err` are never high in the same cycle.

## Timing
- Reset values (asynchronous):
  - state IDLE, counter 0;
  - `Wr_En`=0, `Wr_Addr`=8'h00, `Wr_Data`=8'h00;
  - `Frame_Err`=0, `Err_Code`=2'b00, `Busy`=0.
- All outputs are registered.
- `Wr_En` and `Frame_Err` (checksum case) rise in the cycle after the `Rx_Done` cycle of the CHK byte and last exactly 1 cycle. `Wr_Addr`/`Wr_Data` are valid in that same cycle.
- The timeout `Frame_Err` rises in the cycle after the count reaches `TIMEOUT`-1, i.e. `TIMEOUT` cycles after the last accepted byte.
- `Busy` rises in the cycle after the header's `Rx_Done` and falls in the same cycle as the `Wr_En`/`Frame_Err` pulse.
- Back-to-back bytes are supported (`Rx_Done` in consecutive cycles), so a new header may arrive in the cycle immediately after CHK.
- Reset asserted mid-frame discards all partial state. After release, the parser requires a fresh `HEADER` byte.

## Test plan
- Valid frame: bytes 55, 12, 34, 26 → one `Wr_En` pulse, `Wr_Addr`=12, `Wr_Data`=34, one cycle after the last `Rx_Done`. `Frame_Err` stays 0.
- Bad checksum: bytes 55, 12, 34, 27 → `Frame_Err` pulse, `Err_Code`=01, no `Wr_En`. `Wr_Addr`/`Wr_Data` keep their previous values. Follow with 55, 01, 02, 03 → `Wr_En` with `Wr_Addr`=01, `Wr_Data`=02.
- Garbage then frame: bytes AA, 00, 55, 55, FF, AA → no error on AA/00, and the second 55 is taken as ADDR. Result: `Wr_En` with `Wr_Addr`=55, `Wr_Data`=FF (CHK 55^FF = AA).
- Timeout with `TIMEOUT`=100: send 55, 12, then idle → `Frame_Err` exactly 100 cycles after the 12 byte, `Err_Code`=10, `Busy`=0. A following 55, 12, 34, 26 → `Wr_En`.
- Timeout boundary with `TIMEOUT`=100: send the DATA byte exactly 99 cycles after ADDR → no error, and the frame completes normally. Sending it at cycle 100 instead gives a timeout error, and that late byte is discarded in IDLE.
- Reset mid-frame: send 55, 12, assert `Reset_n`=0 for 3 cycles, release, then send 34, 26 → all outputs at reset values, no `Wr_En`, no `Frame_Err`.
